int2float_arbiter: RTL and testbench

Shares one combinational int2float converter (11-bit integer in, 7-bit float out) among N requesters. Each requester has an 11-bit valid/ready input channel. The block grants one requester per cycle, registers the operand into the converter, registers the converter result, and returns it on a single valid/ready result channel tagged with the requester index. It sits between the requester ports and the shared converter instance.

---
 rtl/int2float_arbiter.sv | 124 ++++++++++++
 tb/tb_int2float_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int2float_arbiter.sv
// int2float_arbiter: N requesters share one combinational 11-bit int -> 7-bit float converter
// through a two-stage pipeline. Define I2F_ARB_RR_EN for round-robin; fixed priority otherwise.
module int2float_arbiter #(
  parameter  int N     = 4,
  parameter  int CNT_W = 16,
  localparam int ID_W  = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_valid,
  input  logic [N*11-1:0]   req_data,
  output logic [N-1:0]      req_ready,
  output logic [10:0]       conv_in,
  input  logic [6:0]        conv_out,
  output logic              res_valid,
  output logic [6:0]        res_data,
  output logic [ID_W-1:0]   res_id,
  input  logic              res_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  done_cnt
);

  logic             r_s1_valid;
  logic [10:0]      r_s1_data;
  logic [ID_W-1:0]  r_s1_id;
  logic             r_res_valid;
  logic [6:0]       r_res_data;
  logic [ID_W-1:0]  r_res_id;
  logic [CNT_W-1:0] r_done_cnt;

  logic             w_s2_load;
  logic             w_s2_drain;
  logic             w_s1_can_accept;
  logic             w_transfer;
  logic [N-1:0]     w_grant;
  logic [N-1:0]     w_ready;
  logic [ID_W-1:0]  w_gidx;
  logic [10:0]      w_sel_data;

  assign w_s2_load       = r_s1_valid && (!r_res_valid || res_ready);
  assign w_s2_drain      = r_res_valid && res_ready;
  assign w_s1_can_accept = !r_s1_valid || w_s2_load;

`ifdef I2F_ARB_RR_EN
  logic [ID_W-1:0] r_ptr;
  logic [N-1:0]    w_mask;
  logic [N-1:0]    w_hi;

  // Requesters at or above ptr win first; if none are valid, wrap to the lowest valid index.
  assign w_mask  = ~((N'(1) << r_ptr) - N'(1));
  assign w_hi    = req_valid & w_mask;
  assign w_grant = (|w_hi) ? (w_hi & (~w_hi + N'(1)))
                           : (req_valid & (~req_valid + N'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_ptr <= '0;
    else if (w_transfer)
      r_ptr <= (w_gidx == ID_W'(N - 1)) ? '0 : w_gidx + 1'b1;
  end
`else
  assign w_grant = req_valid & (~req_valid + N'(1));
`endif

  // Grant is purely a function of req_valid/ptr; readiness only gates it.
  assign w_ready    = rst ? '0 : (w_grant & {N{w_s1_can_accept}});
  assign w_transfer = |(req_valid & w_ready);

  always_comb begin
    w_gidx     = '0;
    w_sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) begin
        w_gidx     = ID_W'(i);
        w_sel_data = req_data[i*11 +: 11];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_id    <= '0;
    end else if (w_transfer) begin
      r_s1_valid <= 1'b1;
      r_s1_data  <= w_sel_data;
      r_s1_id    <= w_gidx;
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  // conv_out is sampled here, one clock after the operand lands in S1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_id    <= '0;
    end else if (w_s2_load) begin
      r_res_valid <= 1'b1;
      r_res_data  <= conv_out;
      r_res_id    <= r_s1_id;
    end else if (w_s2_drain) begin
      r_res_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_done_cnt <= '0;
    else if (w_s2_drain)
      r_done_cnt <= r_done_cnt + 1'b1;
  end

  assign req_ready = w_ready;
  assign conv_in   = r_s1_data;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;
  assign busy      = r_s1_valid || r_res_valid;
  assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_int2float_arbiter.sv
// Scoreboard bench for int2float_arbiter (N=4, CNT_W=4 so the done counter wraps quickly).
// The shared converter is modelled here as a 4-bit exponent / 3-bit mantissa encoding.
module tb_int2float_arbiter;

  typedef struct {
    logic [1:0] id;
    logic [6:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [43:0] req_data = '0;
  logic        res_ready = 1'b0;
  logic [3:0]  req_ready;
  logic [10:0] conv_in;
  logic [6:0]  conv_out;
  logic        res_valid;
  logic [6:0]  res_data;
  logic [1:0]  res_id;
  logic        busy;
  logic [3:0]  done_cnt;

  exp_t sb[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   doneModel  = 0;

  // Exponent = position of the leading one, mantissa = the three bits below it.
  function automatic logic [6:0] i2f(input logic [10:0] x);
    int p;
    logic [10:0] sh;
    if (x == 11'd0) return 7'd0;
    p = 0;
    for (int b = 0; b < 11; b++) if (x[b]) p = b;
    sh = x << (10 - p);
    return {4'(p), sh[9:7]};
  endfunction

  assign conv_out = i2f(conv_in);

  always #5 clk = ~clk;

  int2float_arbiter #(.N(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .conv_in(conv_in), .conv_out(conv_out),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .res_ready(res_ready),
    .busy(busy), .done_cnt(done_cnt)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One clock: observe handshakes mid-cycle, advance, then check the done counter.
  task automatic tick(output int acc);
    exp_t e;
    #2;
    acc = -1;
    vectors++;
    if ($countones(req_ready) > 1) begin
      miscompares++;
      $display("[TB] FAIL onehot: req_ready=%b has more than one bit set", req_ready);
    end
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        acc    = i;
        e.id   = 2'(i);
        e.data = i2f(req_data[i*11 +: 11]);
        sb.push_back(e);
      end
    end
    if (res_valid && res_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL result: unexpected result id=%0d data=%h, none pending", res_id, res_data);
      end else begin
        e = sb.pop_front();
        if (res_id !== e.id || res_data !== e.data) begin
          miscompares++;
          $display("[TB] FAIL result: got id=%0d data=%h, expected id=%0d data=%h",
                   res_id, res_data, e.id, e.data);
        end
      end
      doneModel++;
    end
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (done_cnt !== 4'(doneModel)) begin
      miscompares++;
      $display("[TB] FAIL done_cnt: got %0d, expected %0d", done_cnt, 4'(doneModel));
    end
  endtask

  task automatic applyReset();
    rst = 1'b1;
    #1;
    sb.delete();
    doneModel = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    int acc;
    req_valid = '0;
    res_ready = 1'b1;
    for (int k = 0; k < 8 && busy; k++) tick(acc);
    vectors++;
    if (busy !== 1'b0 || sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: busy=%b pending=%0d, expected busy=0 pending=0", busy, sb.size());
    end
  endtask

  task automatic test_reset();
    req_valid = 4'b1111;
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({res_valid, res_data, res_id, req_ready, conv_in, busy, done_cnt} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset: rv=%b rd=%h id=%0d rr=%b ci=%h busy=%b cnt=%0d, expected all 0",
               res_valid, res_data, res_id, req_ready, conv_in, busy, done_cnt);
    end
    req_valid = '0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int acc;
    res_ready = 1'b1;
    req_valid = 4'b0100;
    req_data[32:22] = 11'h155;
    #1;
    vectors++;
    if (req_ready !== 4'b0100) begin
      miscompares++;
      $display("[TB] FAIL single_ready: got %b, expected 0100", req_ready);
    end
    tick(acc);
    vectors++;
    if (acc != 2) begin
      miscompares++;
      $display("[TB] FAIL single_grant: got %0d, expected 2", acc);
    end
    req_valid = '0;
    tick(acc);
    vectors++;
    if (res_valid !== 1'b1 || res_id !== 2'd2 || res_data !== 7'h42) begin
      miscompares++;
      $display("[TB] FAIL single_result: rv=%b id=%0d data=%h, expected rv=1 id=2 data=42",
               res_valid, res_id, res_data);
    end
    tick(acc);
    vectors++;
    if (done_cnt !== 4'd1 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_done: cnt=%0d busy=%b, expected cnt=1 busy=0", done_cnt, busy);
    end
  endtask

  task automatic test_reset_midstream();
    int acc;
    res_ready = 1'b0;
    req_valid = 4'b0001;
    req_data[10:0] = 11'h0a3;
    tick(acc);
    req_data[10:0] = 11'h3ff;
    tick(acc);
    vectors++;
    if (res_valid !== 1'b1 || busy !== 1'b1 || req_ready !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL mid_full: rv=%b busy=%b rr=%b, expected rv=1 busy=1 rr=0000",
               res_valid, busy, req_ready);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({res_valid, res_data, res_id, req_ready, conv_in, busy, done_cnt} !== '0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset: rv=%b rd=%h id=%0d rr=%b ci=%h busy=%b cnt=%0d, expected all 0",
               res_valid, res_data, res_id, req_ready, conv_in, busy, done_cnt);
    end
    sb.delete();
    doneModel = 0;
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b1111;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin
      miscompares++;
      $display("[TB] FAIL mid_first_grant: got %b, expected 0001", req_ready);
    end
    req_valid = '0;
  endtask

  task automatic test_arbitration();
    int acc;
    int expOrder[6];
`ifdef I2F_ARB_RR_EN
    expOrder = '{0, 1, 2, 3, 0, 1};
`else
    expOrder = '{0, 0, 0, 0, 0, 0};
`endif
    req_data  = {11'h7ff, 11'h400, 11'h0ff, 11'h001};
    req_valid = 4'b1111;
    res_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick(acc);
      vectors++;
      if (acc != expOrder[k]) begin
        miscompares++;
        $display("[TB] FAIL arb_order[%0d]: granted %0d, expected %0d", k, acc, expOrder[k]);
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    int acc;
    res_ready = 1'b0;
    req_valid = 4'b0010;
    req_data[21:11] = 11'h010;
    tick(acc);
    vectors++;
    if (acc != 1) begin
      miscompares++;
      $display("[TB] FAIL bp_xfer0: granted %0d, expected 1", acc);
    end
    req_data[21:11] = 11'h020;
    tick(acc);
    vectors++;
    if (acc != 1) begin
      miscompares++;
      $display("[TB] FAIL bp_xfer1: granted %0d, expected 1", acc);
    end
    req_data[21:11] = 11'h040;
    for (int k = 0; k < 3; k++) begin
      tick(acc);
      vectors++;
      if (acc != -1 || req_ready !== 4'b0000 || busy !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL bp_stall[%0d]: acc=%0d rr=%b busy=%b, expected acc=-1 rr=0000 busy=1",
                 k, acc, req_ready, busy);
      end
    end
    res_ready = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 4'b0010) begin
      miscompares++;
      $display("[TB] FAIL bp_resume: got %b, expected 0010", req_ready);
    end
    tick(acc);
    drain();
  endtask

  task automatic test_counter_wrap();
    int acc;
    int xfers;
    applyReset();
    xfers = 0;
    res_ready = 1'b1;
    req_valid = 4'b0001;
    req_data[10:0] = 11'd5;
    for (int k = 0; k < 40 && doneModel < 17; k++) begin
      tick(acc);
      if (acc == 0) begin
        xfers++;
        req_data[10:0] = 11'(xfers * 37 + 5);
        if (xfers == 17) req_valid = '0;
      end
      if (doneModel == 15 || doneModel == 16 || doneModel == 17) begin
        vectors++;
        if (done_cnt !== 4'(doneModel - 16 * (doneModel / 16))) begin
          miscompares++;
          $display("[TB] FAIL wrap_%0d: done_cnt=%0d, expected %0d",
                   doneModel, done_cnt, doneModel % 16);
        end
      end
    end
    vectors++;
    if (doneModel != 17) begin
      miscompares++;
      $display("[TB] FAIL wrap_timeout: %0d results seen, expected 17", doneModel);
    end
    drain();
  endtask

  initial begin
    $display("[TB] int2float_arbiter bench start");
    test_reset();
    test_single();
    test_reset_midstream();
    test_arbitration();
    test_backpressure();
    test_counter_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
